prim_unpacker: RTL and testbench
================================

# prim_unpacker

Width-reducing unpacker: accepts wide, LSB-aligned, partially masked input words and emits a stream of fixed-width output words, with a flush that drains any residual partial word. It is the read-side counterpart of the packer in the OpenTitan primitive set. It sits between a wide-bus producer (e.g. 32-bit TL-UL/FIFO read data) and a narrow consumer (e.g. 8-bit serializer or hash byte port).

## Interface
- InW, 32, input word width in bits; must satisfy InW >= OutW
- OutW, 8, output word width in bits
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  synchronous, active-high reset
- valid_i  input  1  input word valid
- data_i  input  InW  input data; only bits under mask_i are used
- mask_i  input  InW  valid-bit mask, contiguous ones from bit 0 (thermometer)
- ready_o  output  1  input word accepted this cycle when valid_i & ready_o
- valid_o  output  1  output word valid
- data_o  output  OutW  output data, LSB = oldest bit
- mask_o  output  OutW  output valid-bit mask, thermometer from bit 0
- ready_i  input  1  consumer accepts output when valid_o & ready_i
- flush_i  input  1  single-cycle request to drain residual bits
- flush_done_o  output  1  single-cycle pulse: drain complete

## Operation
- State: buffer buf[BufW-1:0] with BufW = InW+OutW-1; count cnt, PtrW = $clog2(BufW+1) bits; flush FSM.
- ack_in = valid_i & ready_o; ack_out = valid_o & ready_i; pop = popcount(mask_i).
- Input: buf holds cnt valid bits at [cnt-1:0]. On ack_in, (data_i & mask_i) is OR-ed in at bit position cnt' (cnt after any same-cycle ack_out shift) and pop is added to the count.
- Output: data_o = buf[OutW-1:0] & mask_o.
  - mask_o is all ones when cnt >= OutW, else (1<<cnt)-1.
  - valid_o = (cnt >= OutW) | (state==FlushDrain & cnt != 0).
- On ack_out: buf shifts right by OutW (zero fill), and cnt -= min(cnt, OutW).
- Simultaneous ack_out and ack_in: shift first, then insert at the reduced count. Result: cnt_next = cnt - min(cnt, OutW) + pop.
- ready_o = (state==FlushIdle) & ((cnt < OutW) | ((cnt < 2*OutW) & ready_i)).
  - Has a combinational ready_i -> ready_o path.
  - Guarantees cnt_next <= BufW, so the buffer never overflows.
- mask_i all zero with valid_i: accepted, no state change except the handshake.
- Non-contiguous mask_i: illegal; behaviour undefined; an assertion flags it.
- Flush FSM:
  - FlushIdle: flush_i -> FlushDrain. An input accepted in the same cycle is included in the drain.
  - FlushDrain: ready_o = 0; residual words are emitted. The last one is partial with a thermometer mask.
  - FlushDrain and cnt == 0: flush_done_o = 1 (combinational), next state FlushIdle.
  - flush_i while in FlushDrain: ignored.

## Timing
- Reset (rst_i high at clock edge): cnt = 0, buf = 0, state = FlushIdle.
  - Outputs after reset: valid_o = 0, data_o = 0, mask_o = 0, flush_done_o = 0, ready_o = 1.
- Reset mid-operation discards all buffered bits and any pending flush; no flush_done_o is emitted.
- Latency: a word accepted at edge N produces valid_o in cycle N+1 when pop >= OutW.
- Throughput, InW=32/OutW=8 with full masks and ready_i=1: one output per cycle, sustained.
  - The next input is accepted in the cycle the 4th byte is emitted, so there are no bubbles.
- Stalled consumer (ready_i = 0): valid_o, data_o and mask_o hold stable; ready_o = 0 whenever cnt >= OutW.
- Flush with cnt == 0: flush_done_o pulses the cycle after flush_i.
- Flush with cnt = k: drain takes ceil(k/OutW) output acks, then flush_done_o one cycle later.

## Structure
- Shared package prim_unpacker_pkg holds:
  - flush_st_e {FlushIdle, FlushDrain} (1 bit);
  - the functions buf_w(InW, OutW) and ptr_w(InW, OutW) used for BufW and PtrW.
- One sub-module: prim_unpacker_popcnt (parameter W), a combinational popcount of mask_i with output width $clog2(W+1).
- Buffer, count and FSM live in the top module.
- Elaboration-time check: InW >= OutW.

## Test plan
- Reset then full word: InW=32/OutW=8, data_i=32'hDDCCBBAA, mask_i all ones, ready_i=1.
  - Required: 4 consecutive outputs AA, BB, CC, DD, each mask_o=8'hFF; ready_o=1 again in the 4th output cycle.
- Back-to-back full words, ready_i=1: 8 consecutive bytes, no gap in valid_o, no lost or duplicated byte.
- Partial word plus flush: mask_i=32'h000FFFFF (20 bits), data_i=32'h000ABCDE, then flush_i.
  - Required: DE/FF, BC/FF, 0A/0F (partial), then flush_done_o pulse, then ready_o=1.
- Straddling words: two inputs with mask 12 bits each (12'hABC, 12'h123), then flush.
  - Required: BC/FF, 3A/FF, 12/FF; then flush_done_o; cnt returns to 0.
- Backpressure: ready_i=0 for 5 cycles mid-word.
  - Required: valid_o=1 and data_o/mask_o stable throughout; ready_o=0; the byte order is unchanged after release.
- Reset mid-drain: assert rst_i during FlushDrain with cnt=12.
  - Required next cycle: valid_o=0, flush_done_o=0, ready_o=1; the next word is unpacked from bit 0.

Source files
------------

// File: rtl/prim_unpacker_pkg.sv
// Shared types and sizing helpers for the width-reducing unpacker.
package prim_unpacker_pkg;

  typedef enum logic [0:0] {
    FlushIdle  = 1'b0,
    FlushDrain = 1'b1
  } flush_st_e;

  // Buffer must hold a residual partial output word plus one full input word.
  function automatic int unsigned buf_w(input int unsigned in_w, input int unsigned out_w);
    return in_w + out_w - 1;
  endfunction

  function automatic int unsigned ptr_w(input int unsigned in_w, input int unsigned out_w);
    return $clog2(buf_w(in_w, out_w) + 1);
  endfunction

endpackage

// File: rtl/prim_unpacker_popcnt.sv
// Combinational population count of a mask vector.
module prim_unpacker_popcnt #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0]           mask_i,
  output logic [$clog2(W+1)-1:0] cnt_o
);

  localparam int unsigned CntW = $clog2(W + 1);

  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < W; i++) begin
      cnt_o = cnt_o + CntW'(mask_i[i]);
    end
  end

endmodule

// File: rtl/prim_unpacker.sv
// Width-reducing unpacker: wide masked input words in, fixed-width output words out,
// with a flush that drains the residual partial word.
module prim_unpacker
  import prim_unpacker_pkg::*;
#(
  parameter int unsigned InW  = 32,
  parameter int unsigned OutW = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [InW-1:0]  data_i,
  input  logic [InW-1:0]  mask_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [OutW-1:0] data_o,
  output logic [OutW-1:0] mask_o,
  input  logic            ready_i,
  input  logic            flush_i,
  output logic            flush_done_o
);

  localparam int unsigned BufW = buf_w(InW, OutW);
  localparam int unsigned PtrW = ptr_w(InW, OutW);
  localparam int unsigned PopW = $clog2(InW + 1);
  localparam int unsigned CmpW = PtrW + 1;

  if (InW < OutW) begin : gen_width_check
    $error("prim_unpacker: InW must be >= OutW");
  end

  logic [BufW-1:0] buf_q, buf_d, buf_sh;
  logic [PtrW-1:0] cnt_q, cnt_d, cnt_sh;
  flush_st_e       state_q, state_d;
  logic [PopW-1:0] pop;
  logic            ack_in, ack_out, ge_out;

  prim_unpacker_popcnt #(
    .W (InW)
  ) u_popcnt (
    .mask_i (mask_i),
    .cnt_o  (pop)
  );

  assign ge_out  = cnt_q >= PtrW'(OutW);
  assign valid_o = ge_out | ((state_q == FlushDrain) & (cnt_q != '0));
  assign data_o  = buf_q[OutW-1:0] & mask_o;

  // The upper term lets a new word in while the last full byte leaves, keeping cnt_d <= BufW.
  assign ready_o = (state_q == FlushIdle) &
                   ((cnt_q < PtrW'(OutW)) |
                    (({1'b0, cnt_q} < CmpW'(2 * OutW)) & ready_i));

  assign ack_in  = valid_i & ready_o;
  assign ack_out = valid_o & ready_i;

  // Thermometer mask over the bits currently buffered.
  always_comb begin
    mask_o = '0;
    for (int unsigned i = 0; i < OutW; i++) begin
      mask_o[i] = cnt_q > PtrW'(i);
    end
  end

  // Shift out first, then append the new word at the reduced count.
  always_comb begin
    buf_sh = buf_q;
    cnt_sh = cnt_q;
    if (ack_out) begin
      buf_sh = buf_q >> OutW;
      cnt_sh = ge_out ? cnt_q - PtrW'(OutW) : '0;
    end
    buf_d = buf_sh;
    cnt_d = cnt_sh;
    if (ack_in) begin
      buf_d = buf_sh | (BufW'(data_i & mask_i) << cnt_sh);
      cnt_d = cnt_sh + PtrW'(pop);
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_done_o = 1'b0;
    case (state_q)
      FlushIdle: begin
        if (flush_i) state_d = FlushDrain;
      end
      FlushDrain: begin
        if (cnt_q == '0) begin
          flush_done_o = 1'b1;
          state_d      = FlushIdle;
        end
      end
      default: state_d = FlushIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      state_q <= FlushIdle;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Masks must be thermometer-coded from bit 0.
  mask_contiguous_a: assert property (@(posedge clk_i) disable iff (rst_i)
    valid_i |-> ((mask_i & (mask_i + InW'(1))) == '0));

endmodule

// File: tb/tb_prim_unpacker.sv
// Self-checking bench for prim_unpacker: directed vector table plus randomized
// traffic checked against a bit-queue reference model.
module tb_prim_unpacker;

  localparam int unsigned InW  = 32;
  localparam int unsigned OutW = 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            valid_i;
  logic [InW-1:0]  data_i;
  logic [InW-1:0]  mask_i;
  logic            ready_o;
  logic            valid_o;
  logic [OutW-1:0] data_o;
  logic [OutW-1:0] mask_o;
  logic            ready_i;
  logic            flush_i;
  logic            flush_done_o;

  prim_unpacker #(
    .InW  (InW),
    .OutW (OutW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .mask_i       (mask_i),
    .ready_o      (ready_o),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .mask_o       (mask_o),
    .ready_i      (ready_i),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic            rst;
    logic            valid;
    logic [InW-1:0]  data;
    logic [InW-1:0]  mask;
    logic            rdy;
    logic            flush;
    logic            ev;
    logic [OutW-1:0] ed;
    logic [OutW-1:0] em;
    logic            er;
    logic            edone;
    logic            chk;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO of individual bits, oldest first, plus a drain flag.
  bit mq[$];
  bit m_drain;

  function automatic vec_t mk(input logic rst, input logic valid, input logic [InW-1:0] data,
                              input logic [InW-1:0] mask, input logic rdy, input logic flush,
                              input logic ev, input logic [OutW-1:0] ed, input logic [OutW-1:0] em,
                              input logic er, input logic edone);
    vec_t v;
    v.rst = rst; v.valid = valid; v.data = data; v.mask = mask; v.rdy = rdy; v.flush = flush;
    v.ev = ev; v.ed = ed; v.em = em; v.er = er; v.edone = edone; v.chk = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic model_outs(input logic rdy, output logic ev, output logic [OutW-1:0] ed,
                            output logic [OutW-1:0] em, output logic er, output logic edone);
    int n;
    n  = mq.size();
    ed = '0;
    em = '0;
    for (int i = 0; i < int'(OutW); i++) begin
      if (i < n) begin
        em[i] = 1'b1;
        ed[i] = mq[i];
      end
    end
    ev    = (n >= int'(OutW)) || (m_drain && n != 0);
    er    = !m_drain && ((n < int'(OutW)) || ((n < 2 * int'(OutW)) && rdy));
    edone = m_drain && (n == 0);
  endtask

  task automatic cycle(input vec_t v, input int idx);
    logic ev, er, edone;
    logic [OutW-1:0] ed, em;
    int n;
    rst_i = v.rst; valid_i = v.valid; data_i = v.data; mask_i = v.mask;
    ready_i = v.rdy; flush_i = v.flush;
    @(negedge clk_i);
    model_outs(v.rdy, ev, ed, em, er, edone);
    chk("model valid_o", idx, 32'(valid_o), 32'(ev));
    chk("model data_o", idx, 32'(data_o), 32'(ed));
    chk("model mask_o", idx, 32'(mask_o), 32'(em));
    chk("model ready_o", idx, 32'(ready_o), 32'(er));
    chk("model flush_done_o", idx, 32'(flush_done_o), 32'(edone));
    if (v.chk) begin
      chk("vec valid_o", idx, 32'(valid_o), 32'(v.ev));
      chk("vec data_o", idx, 32'(data_o), 32'(v.ed));
      chk("vec mask_o", idx, 32'(mask_o), 32'(v.em));
      chk("vec ready_o", idx, 32'(ready_o), 32'(v.er));
      chk("vec flush_done_o", idx, 32'(flush_done_o), 32'(v.edone));
    end
    @(posedge clk_i);
    n = mq.size();
    if (v.rst) begin
      mq.delete();
      m_drain = 1'b0;
    end else begin
      if (ev && v.rdy) begin
        for (int i = 0; i < ((n < int'(OutW)) ? n : int'(OutW)); i++) void'(mq.pop_front());
      end
      if (v.valid && er) begin
        for (int i = 0; i < int'(InW); i++) if (v.mask[i]) mq.push_back(v.data[i]);
      end
      if (m_drain) begin
        if (n == 0) m_drain = 1'b0;
      end else if (v.flush) begin
        m_drain = 1'b1;
      end
    end
    #1;
  endtask

  localparam logic [InW-1:0] F = '1;
  vec_t tbl[$];

  initial begin
    // Full word, ready drops for 3 bytes, returns on the 4th.
    tbl.push_back(mk(0, 1, 32'hDDCCBBAA, F, 1, 0, 0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8'hAA, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8'hBB, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8'hCC, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8'hDD, 8'hFF, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0));
    // Back-to-back words: second accepted alongside the 4th byte, no gap.
    tbl.push_back(mk(0, 1, 32'h44332211, F, 1, 0, 0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(0, 1, 32'h88776655, F, 1, 0, 1, 8'h11, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 1, 32'h88776655, F, 1, 0, 1, 8'h22, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 1, 32'h88776655, F, 1, 0, 1, 8'h33, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 1, 32'h88776655, F, 1, 0, 1, 8'h44, 8'hFF, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8'h55, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8'h66, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8'h77, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8'h88, 8'hFF, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0));
    // 20-bit partial word then flush.
    tbl.push_back(mk(0, 1, 32'h000ABCDE, 32'h000FFFFF, 1, 0, 0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 8'hDE, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8'hBC, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8'h0A, 8'h0F, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0));
    // Two 12-bit words straddling a byte boundary, then flush.
    tbl.push_back(mk(0, 1, 32'h00000ABC, 32'h00000FFF, 1, 0, 0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(0, 1, 32'h00000123, 32'h00000FFF, 1, 0, 1, 8'hBC, 8'hFF, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 8'h3A, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8'h12, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0));
    // Backpressure: consumer stalls 5 cycles on byte BB.
    tbl.push_back(mk(0, 1, 32'hDDCCBBAA, F, 1, 0, 0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8'hAA, 8'hFF, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8'hBB, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8'hBB, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8'hCC, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8'hDD, 8'hFF, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0));
    // Flush with nothing buffered, then flush_i ignored while draining.
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0));
    // Reset during drain with 12 bits left; next word starts at bit 0.
    tbl.push_back(mk(0, 1, 32'h000ABCDE, 32'h000FFFFF, 1, 0, 0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 8'hDE, 8'hFF, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 8'hBC, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 1, 32'h000000C3, 32'h000000FF, 1, 0, 0, 8'h00, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 8'hC3, 8'hFF, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 0));

    rst_i = 1'b1; valid_i = 1'b0; data_i = '0; mask_i = '0; ready_i = 1'b0; flush_i = 1'b0;
    m_drain = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    foreach (tbl[i]) cycle(tbl[i], i);

    for (int c = 0; c < 2000; c++) begin
      vec_t v;
      int len;
      logic [InW:0] t;
      len = $urandom_range(0, InW);
      t   = ((InW+1)'(1) << len) - (InW+1)'(1);
      v   = mk($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, $urandom, t[InW-1:0],
               $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 0, 8'h00, 8'h00, 0, 0);
      v.chk = 1'b0;
      cycle(v, 1000 + c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
